count_checker: RTL

Hardware stream checker placed directly downstream of the 4-bit free-running `counter`. It consumes the counter's `count` output every clock and locks onto the incrementing sequence. Once locked, it reports any deviation as a mismatch pulse, a saturating error count and a capture of the first bad sample. It also counts wrap-arounds, so system-level software can confirm the counter is alive without a simulation-only reference model.

---
 rtl/count_checker_pkg.sv | 13 +
 rtl/sat_counter.sv | 25 ++
 rtl/count_checker.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/count_checker_pkg.sv
// Shared types and default widths for the count stream checker.
package count_checker_pkg;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } chk_state_t;

  localparam int DEF_WIDTH        = 4;
  localparam int DEF_LOCK_MATCHES = 4;
  localparam int DEF_CNT_WIDTH    = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear with a same-cycle
// increment restarts the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  // NOTE: flops use non-blocking assignments so every register updates from
  // pre-edge values, independent of the order of the always blocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= inc ? W'(1) : '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/count_checker.sv
// Checks a free-running counter stream: locks on consecutive increments, then
// flags deviations, captures the first bad sample and counts wrap-arounds.
module count_checker
  import count_checker_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int LOCK_MATCHES = DEF_LOCK_MATCHES,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 sync_req,
  input  logic                 clear,
  output logic                 locked,
  output logic                 mismatch,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 err_sticky,
  output logic [WIDTH-1:0]     first_bad,
  output logic [WIDTH-1:0]     first_exp,
  output logic                 wrap_pulse,
  output logic [CNT_WIDTH-1:0] wrap_count
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_MATCHES);

  chk_state_t       state, state_next;
  logic [WIDTH-1:0] prev, prev_next, prev_inc;
  logic [WIDTH-1:0] expected, expected_next;
  logic             prev_valid, prev_valid_next;
  logic [3:0]       run, run_next, run_inc;
  logic             mismatch_next, wrap_next, capture;

  assign prev_inc = prev + 1'b1;
  assign run_inc  = run + 4'd1;
  assign locked   = (state == TRACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ACQUIRE;
      prev       <= '0;
      prev_valid <= 1'b0;
      run        <= '0;
      expected   <= '0;
      mismatch   <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_next;
      prev       <= prev_next;
      prev_valid <= prev_valid_next;
      run        <= run_next;
      expected   <= expected_next;
      mismatch   <= mismatch_next;
      wrap_pulse <= wrap_next;
    end
  end

  always_comb begin
    // NOTE: every next-value gets a default first, so no path through the
    // branches below leaves a signal unassigned and infers a latch.
    state_next      = state;
    prev_next       = prev;
    prev_valid_next = prev_valid;
    run_next        = run;
    expected_next   = expected;
    mismatch_next   = 1'b0;
    wrap_next       = 1'b0;

    if (sync_req) begin
      state_next      = ACQUIRE;
      prev_valid_next = 1'b0;
      run_next        = '0;
    end else begin
      case (state)
        ACQUIRE: begin
          prev_next = count_in;
          if (!prev_valid) begin
            prev_valid_next = 1'b1;
            run_next        = '0;
          end else if (count_in == prev_inc) begin
            run_next = run_inc;
            if (run_inc == LOCK_TARGET) begin
              state_next    = TRACK;
              expected_next = count_in + 1'b1;
            end
          end else begin
            run_next = '0;
          end
        end
        TRACK: begin
          if (count_in == expected) begin
            expected_next = expected + 1'b1;
            wrap_next     = &count_in;
          end else begin
            mismatch_next   = 1'b1;
            state_next      = ACQUIRE;
            prev_valid_next = 1'b0;
          end
        end
        default: state_next = ACQUIRE;
      endcase
    end
  end

  // A mismatch in the same cycle as clear opens the new epoch with itself.
  assign capture = mismatch_next && (!err_sticky || clear);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sticky <= 1'b0;
      first_bad  <= '0;
      first_exp  <= '0;
    end else begin
      if (mismatch_next) begin
        err_sticky <= 1'b1;
      end else if (clear) begin
        err_sticky <= 1'b0;
      end
      if (capture) begin
        first_bad <= count_in;
        first_exp <= expected;
      end else if (clear) begin
        first_bad <= '0;
        first_exp <= '0;
      end
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (mismatch_next),
    .clr   (clear),
    .value (err_count)
  );

  sat_counter #(.W(CNT_WIDTH)) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_next),
    .clr   (clear),
    .value (wrap_count)
  );

endmodule
